// File: rtl/line_buffer_l1.sv
// 3x3 sliding-window generator over a square raster frame with one-pixel zero padding.
// Two line buffers hold the previous rows; a FLUSH phase pushes zero beats to drain the last row.
module line_buffer_l1 #(
  parameter int F  = 28,
  parameter int B  = 8,
  parameter int kx = 3,
  parameter int ky = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [B-1:0]          i_pixel,
  input  logic                  i_pixel_valid,
  output logic                  o_ready,
  output logic [kx*ky*B-1:0]    o_pixel_data,
  output logic                  o_pixel_data_valid,
  output logic                  o_frame_done
);

  localparam int K  = 3;
  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam int RW = $clog2(F + 2);

  localparam logic [CW-1:0] COL_ZERO = '0;
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(F - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(F - 1);
  localparam logic [RW-1:0] ROW_F    = RW'(F);
  localparam logic [RW-1:0] ROW_END  = RW'(F + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            beat, emit, in_last, flush_last;
  logic [B-1:0]    pix_in;
  logic [B-1:0]    lb_top [F];
  logic [B-1:0]    lb_mid [F];
  logic [B-1:0]    col_in [K];
  logic [B-1:0]    win    [K][K];
  logic [B-1:0]    win_nx [K][K];
  logic            zero_top, zero_bot, zero_left, zero_right;
  logic [K*K*B-1:0] data_nx;

  assign o_ready    = (state != FLUSH);
  assign beat       = (state == FLUSH) || (i_pixel_valid && o_ready);
  assign pix_in     = (state == FLUSH) ? '0 : i_pixel;
  assign in_last    = (row == ROW_LAST) && (col == COL_LAST);
  assign flush_last = (state == FLUSH) && (row == ROW_END);
  // The first window (0,0) follows the beat at linear index F+1.
  assign emit       = (row >= ROW_TWO) || ((row == ROW_ONE) && (col != COL_ZERO));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (beat) state_nx = FILL;
      FILL:  if (beat && (row == ROW_ONE) && (col == COL_ZERO)) state_nx = RUN;
      RUN:   if (beat && in_last) state_nx = FLUSH;
      FLUSH: if (flush_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (flush_last) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_ONE;
      end else begin
        col <= col + COL_ONE;
      end
    end
  end

  // NOTE: line buffers carry no reset; stale rows are always hidden by the counter-based padding.
  always_ff @(posedge i_clk) begin
    if (beat) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix_in;
    end
  end

  always_comb begin
    col_in[0] = lb_top[col];
    col_in[1] = lb_mid[col];
    col_in[2] = pix_in;
    for (int r = 0; r < K; r++) begin
      win_nx[r][0] = win[r][1];
      win_nx[r][1] = win[r][2];
      win_nx[r][2] = col_in[r];
    end
    // Column 0 of the incoming beat means the window centre sits at the right edge of the row above.
    zero_left  = (col == COL_ONE);
    zero_right = (col == COL_ZERO);
    zero_top   = (col == COL_ZERO) ? (row == ROW_TWO) : (row == ROW_ONE);
    zero_bot   = (col == COL_ZERO) ? (row == ROW_END) : (row == ROW_F);
    data_nx = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (!((r == 0 && zero_top) || (r == K-1 && zero_bot) ||
              (c == 0 && zero_left) || (c == K-1 && zero_right)))
          data_nx[(K*r+c)*B +: B] = win_nx[r][c];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
    end else if (beat) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= win_nx[r][c];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
    end else begin
      o_pixel_data_valid <= beat && emit;
      o_frame_done       <= beat && flush_last;
      if (beat && emit) o_pixel_data <= data_nx;
    end
  end

endmodule

// File: tb/tb_line_buffer_l1.sv
// Directed bench for line_buffer_l1: ramp, gapped, reset-aborted and back-to-back frames.
// A negedge monitor compares every emitted window against a padded-window model.
module tb_line_buffer_l1;

  localparam int F  = 28;
  localparam int B  = 8;
  localparam int DW = 9 * B;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [B-1:0]  i_pixel = '0;
  logic          i_pixel_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_frame_done;

  int checks = 0;
  int errors = 0;
  int kind_q[$];
  int mon_r = 0, mon_c = 0, mon_cnt = 0, done_cnt = 0;

  line_buffer_l1 dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pixel            (i_pixel),
    .i_pixel_valid      (i_pixel_valid),
    .o_ready            (o_ready),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_frame_done       (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [B-1:0] pix(input int kind, input int r, input int c);
    return (kind == 0) ? B'((r * F + c) % 256) : '1;
  endfunction

  function automatic logic [DW-1:0] exp_win(input int kind, input int r, input int c);
    logic [DW-1:0] w = '0;
    for (int k = 0; k < 9; k++) begin
      int rr = r + k / 3 - 1;
      int cc = c + k % 3 - 1;
      if (rr >= 0 && rr < F && cc >= 0 && cc < F) w[k*B +: B] = pix(kind, rr, cc);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [B-1:0] p);
    bit acc;
    i_pixel_valid = 1'b1;
    i_pixel = p;
    for (int t = 0; t < 200; t++) begin
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (acc) return;
    end
    check("beat_timeout", DW'(0), DW'(1));
  endtask

  task automatic gap();
    i_pixel_valid = 1'b0;
    i_pixel = B'($urandom);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("gap_valid", DW'(o_pixel_data_valid), DW'(0));
  endtask

  // Window-order monitor: every valid must be the next window of the current frame.
  always @(negedge i_clk) begin
    if (i_rst) begin
      mon_r = 0;
      mon_c = 0;
      mon_cnt = 0;
    end else if (o_pixel_data_valid) begin
      int k;
      k = (kind_q.size() > 0) ? kind_q[0] : 0;
      check("window", o_pixel_data, exp_win(k, mon_r, mon_c));
      check("frame_done", DW'(o_frame_done), DW'(mon_r == F-1 && mon_c == F-1));
      mon_cnt++;
      if (o_frame_done) done_cnt++;
      if (mon_r == F-1 && mon_c == F-1) begin
        check("window_count", DW'(mon_cnt), DW'(F * F));
        mon_cnt = 0;
        mon_r = 0;
        mon_c = 0;
        if (kind_q.size() > 0) void'(kind_q.pop_front());
      end else if (mon_c == F-1) begin
        mon_c = 0;
        mon_r++;
      end else begin
        mon_c++;
      end
    end
  end

  initial begin
    int low, vcnt, done_at, done_before;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_ready", DW'(o_ready), DW'(1));
    check("rst_valid", DW'(o_pixel_data_valid), DW'(0));
    check("rst_done", DW'(o_frame_done), DW'(0));
    check("rst_data", o_pixel_data, DW'(0));
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Frame A: ramp, valid every cycle, with directed window and flush checks
    kind_q.push_back(0);
    for (int n = 0; n < F * F; n++) begin
      send(pix(0, n / F, n % F));
      if (n == 28) begin
        @(negedge i_clk);
        check("no_valid_before_29", DW'(o_pixel_data_valid), DW'(0));
      end
      if (n == 29) begin
        @(negedge i_clk);
        check("first_valid", DW'(o_pixel_data_valid), DW'(1));
        check("win_0_0", o_pixel_data,
              {8'd29, 8'd28, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      end
      if (n == 174) begin
        @(negedge i_clk);
        check("win_5_5", o_pixel_data,
              {8'd174, 8'd173, 8'd172, 8'd146, 8'd145, 8'd144, 8'd118, 8'd117, 8'd116});
      end
      if (n == 202) begin
        @(negedge i_clk);
        check("win_6_5", o_pixel_data,
              {8'd202, 8'd201, 8'd200, 8'd174, 8'd173, 8'd172, 8'd146, 8'd145, 8'd144});
      end
    end
    i_pixel_valid = 1'b0;
    low = 0;
    vcnt = 0;
    done_at = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge i_clk);
      if (!o_ready) low++;
      if (o_pixel_data_valid) vcnt++;
      if (o_pixel_data_valid && o_frame_done) begin
        done_at = i;
        check("win_27_27", o_pixel_data,
              {8'd0, 8'd0, 8'd0, 8'd0, 8'd15, 8'd14, 8'd0, 8'd243, 8'd242});
      end
    end
    check("flush_ready_low", DW'(low), DW'(29));
    check("flush_valids", DW'(vcnt), DW'(30));
    check("flush_done_cycle", DW'(done_at), DW'(30));
    check("frames_after_A", DW'(done_cnt), DW'(1));

    // Frame B: same ramp with random 50% gaps
    @(posedge i_clk);
    #1;
    kind_q.push_back(0);
    for (int n = 0; n < F * F; n++) begin
      if ($urandom_range(1, 0) == 1) gap();
      send(pix(0, n / F, n % F));
    end
    i_pixel_valid = 1'b0;
    repeat (40) @(posedge i_clk);
    #1;
    check("frames_after_B", DW'(done_cnt), DW'(2));

    // Reset at beat 400, then a clean frame
    kind_q.push_back(0);
    for (int n = 0; n < 400; n++) send(pix(0, n / F, n % F));
    i_pixel_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    check("async_rst_ready", DW'(o_ready), DW'(1));
    check("async_rst_valid", DW'(o_pixel_data_valid), DW'(0));
    check("async_rst_data", o_pixel_data, DW'(0));
    kind_q.delete();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("post_rst_quiet", DW'(o_pixel_data_valid), DW'(0));
    end
    @(posedge i_clk);
    #1;
    kind_q.push_back(0);
    for (int n = 0; n < F * F; n++) begin
      send(pix(0, n / F, n % F));
      if (n == 29) begin
        @(negedge i_clk);
        check("post_rst_win_0_0", o_pixel_data,
              {8'd29, 8'd28, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      end
    end
    i_pixel_valid = 1'b0;
    repeat (40) @(posedge i_clk);
    #1;
    check("frames_after_rst", DW'(done_cnt), DW'(3));

    // Back-to-back: ramp frame then all-0xFF frame with no idle between
    done_before = done_cnt;
    kind_q.push_back(0);
    kind_q.push_back(1);
    for (int n = 0; n < F * F; n++) send(pix(0, n / F, n % F));
    for (int n = 0; n < F * F; n++) begin
      send(pix(1, n / F, n % F));
      if (n == 29) begin
        @(negedge i_clk);
        check("ff_win_0_0", o_pixel_data,
              {8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0});
      end
    end
    i_pixel_valid = 1'b0;
    repeat (40) @(posedge i_clk);
    #1;
    check("b2b_done_pulses", DW'(done_cnt - done_before), DW'(2));
    check("final_ready", DW'(o_ready), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
